// File: rtl/mem_wb_if.sv
// MEM/WB boundary bus.
// The master side is the memory stage and the upstream control.
// The slave side is the MEM/WB stage, which returns the stall request and the
// writeback packet.
interface mem_wb_if;
  logic        valid_in;
  logic        memRead;
  logic        memWrite;
  logic        memToReg;
  logic        regWrite;
  logic [2:0]  writeReg;
  logic        HALT;
  logic [15:0] aluResult;
  logic [15:0] readData;
  logic        done_reading;
  logic        stall_from_mem;
  logic        err;

  logic        mem_stall_out;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic [2:0]  wb_reg;
  logic        wb_regWrite;
  logic        wb_halt;
  logic        wb_err;

  modport mst (
    output valid_in, memRead, memWrite, memToReg, regWrite, writeReg, HALT,
           aluResult, readData, done_reading, stall_from_mem, err,
    input  mem_stall_out, wb_valid, wb_data, wb_reg, wb_regWrite, wb_halt, wb_err
  );

  modport slv (
    input  valid_in, memRead, memWrite, memToReg, regWrite, writeReg, HALT,
           aluResult, readData, done_reading, stall_from_mem, err,
    output mem_stall_out, wb_valid, wb_data, wb_reg, wb_regWrite, wb_halt, wb_err
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline boundary.
// The stage waits for the data-memory access to finish, then registers the
// writeback packet. It freezes upstream stages while an access is outstanding.
// A watchdog forces an error completion if the memory never answers.
module mem_wb_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic   clk,
  input  logic   rst,
  mem_wb_if.slv  bus
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_t      state_q;
  logic [7:0]  cnt_q;

  logic        wb_valid_q;
  logic [15:0] wb_data_q;
  logic [2:0]  wb_reg_q;
  logic        wb_regWrite_q;
  logic        wb_halt_q;
  logic        wb_err_q;

  // Instruction fields held while the access is outstanding
  logic        lat_m2r_q;
  logic        lat_rw_q;
  logic [2:0]  lat_reg_q;
  logic        lat_halt_q;
  logic [15:0] lat_alu_q;

  logic memop;
  logic m2r_eff;
  logic miss_start;
  logic wait_timeout;
  logic stall_d;

  assign memop        = bus.memRead | bus.memWrite;
  // A store never writes back memory data
  assign m2r_eff      = bus.memToReg & ~bus.memWrite;
  assign miss_start   = (state_q == S_IDLE) & bus.valid_in & memop & ~bus.done_reading;
  assign wait_timeout = (state_q == S_WAIT) & ~bus.done_reading & (cnt_q == TO_CNT);

  // Upstream freeze: pending access, or memory system busy for a memory op
  always_comb begin
    stall_d = 1'b0;
    if (!rst) begin
      if (state_q == S_IDLE)
        stall_d = bus.valid_in & memop & ~bus.done_reading;
      else
        stall_d = ~bus.done_reading & (cnt_q != TO_CNT);
      if (bus.valid_in & memop & bus.stall_from_mem)
        stall_d = 1'b1;
    end
  end

  // Capture instruction fields on the cycle a miss begins
  always_ff @(posedge clk) begin
    if (miss_start) begin
      lat_m2r_q  <= m2r_eff;
      lat_rw_q   <= bus.regWrite;
      lat_reg_q  <= bus.writeReg;
      lat_halt_q <= bus.HALT;
      lat_alu_q  <= bus.aluResult;
    end
  end

  // Access FSM with watchdog and registered writeback packet
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 8'd0;
      wb_valid_q    <= 1'b0;
      wb_data_q     <= 16'h0000;
      wb_reg_q      <= 3'd0;
      wb_regWrite_q <= 1'b0;
      wb_halt_q     <= 1'b0;
      wb_err_q      <= 1'b0;
    end else begin
      wb_valid_q    <= 1'b0;
      wb_regWrite_q <= 1'b0;
      wb_halt_q     <= 1'b0;
      wb_err_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.valid_in) begin
            if (!memop || bus.done_reading) begin
              wb_valid_q    <= 1'b1;
              wb_data_q     <= (memop && m2r_eff) ? bus.readData : bus.aluResult;
              wb_reg_q      <= bus.writeReg;
              wb_regWrite_q <= bus.regWrite & ~(memop & bus.err);
              wb_halt_q     <= bus.HALT;
              wb_err_q      <= memop & bus.err;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= 8'd1;
            end
          end
        end
        S_WAIT: begin
          if (bus.done_reading) begin
            wb_valid_q    <= 1'b1;
            wb_data_q     <= lat_m2r_q ? bus.readData : lat_alu_q;
            wb_reg_q      <= lat_reg_q;
            wb_regWrite_q <= lat_rw_q & ~bus.err;
            wb_halt_q     <= lat_halt_q;
            wb_err_q      <= bus.err;
            state_q       <= S_IDLE;
          end else if (wait_timeout) begin
            wb_valid_q    <= 1'b1;
            wb_data_q     <= 16'h0000;
            wb_reg_q      <= lat_reg_q;
            wb_regWrite_q <= 1'b0;
            wb_halt_q     <= lat_halt_q;
            wb_err_q      <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_stall_out = stall_d;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.wb_reg        = wb_reg_q;
  assign bus.wb_regWrite   = wb_regWrite_q;
  assign bus.wb_halt       = wb_halt_q;
  assign bus.wb_err        = wb_err_q;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Sits directly downstream of the memory stage, acting as the MEM/WB boundary.
- Waits for the data-memory access to complete (done_reading / stall_from_mem handshake), then captures the load data or ALU result.
- Registers the writeback packet (data, destination register, write enable, halt, error).
- Back-pressures upstream stages while a memory access is outstanding.
- Includes a watchdog that flags a hung memory access.

Parameters:
- TIMEOUT, 64, max cycles in WAIT before a forced error completion; legal range 2..255.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- valid_in  input  1  an instruction is present in the memory stage this cycle
- memRead  input  1  instruction is a load
- memWrite  input  1  instruction is a store
- memToReg  input  1  writeback source: 1 = readData, 0 = aluResult
- regWrite  input  1  instruction writes the register file
- writeReg  input  3  destination register number
- HALT  input  1  instruction is a halt
- aluResult  input  16  ALU result / memory address
- readData  input  16  data from the memory stage, valid only in the done_reading cycle
- done_reading  input  1  memory access completes this cycle
- stall_from_mem  input  1  memory system busy
- err  input  1  memory system error, sampled with done_reading
- mem_stall_out  output  1  freeze upstream pipeline registers this cycle
- wb_valid  output  1  writeback packet valid
- wb_data  output  16  writeback data
- wb_reg  output  3  writeback destination
- wb_regWrite  output  1  register-file write enable (already gated by wb_valid)
- wb_halt  output  1  halt reached writeback
- wb_err  output  1  memory error or timeout for this instruction

Behaviour:
- All outputs are registered except mem_stall_out.
- Reset:
  - state = IDLE, timeout counter = 0.
  - wb_valid, wb_regWrite, wb_halt and wb_err = 0; wb_data = 0x0000; wb_reg = 0.
  - mem_stall_out = 0 while rst is high.
- memop = memRead | memWrite.
- State IDLE:
  - valid_in = 0: wb_valid <= 0 next edge; all wb_* control bits <= 0.
  - valid_in = 1 and memop = 0: capture next edge. wb_data <= aluResult; wb_valid <= 1; remaining fields from the inputs. Latency is 1 cycle.
  - valid_in = 1, memop = 1, done_reading = 1 in the same cycle (cache hit): capture next edge. wb_data <= memToReg ? readData : aluResult; wb_err <= err.
  - valid_in = 1, memop = 1, done_reading = 0: go to WAIT.
    - Latch memToReg, regWrite, writeReg, HALT and aluResult internally.
    - wb_valid <= 0; counter <= 1.
- State WAIT:
  - done_reading = 1: capture using the latched fields and the current readData/err; wb_valid <= 1; next state IDLE. Inputs valid_in and the other instruction fields are ignored in this cycle; the upstream freeze keeps them stable.
  - done_reading = 0 and counter == TIMEOUT:
    - Forced completion: wb_valid <= 1, wb_err <= 1, wb_regWrite <= 0, wb_data <= 0x0000.
    - Next state IDLE.
  - Otherwise: counter increments; wb_valid <= 0.
- mem_stall_out (combinational):
  - 1 when (IDLE & valid_in & memop & ~done_reading) or (WAIT & ~done_reading & counter != TIMEOUT).
  - 0 in the completion cycle.
  - stall_from_mem is ORed in only when valid_in & memop.
- Field rules:
  - wb_regWrite = captured regWrite & wb_valid & ~wb_err.
  - A store with memToReg = 1 is treated as memToReg = 0.
  - wb_halt is captured only with a valid packet.
- Every wb_valid pulse lasts exactly 1 cycle per instruction; there are no duplicates after a WAIT.
- Reset asserted in WAIT aborts the access: no packet is produced, and the state is IDLE after the edge.
- done_reading arriving in IDLE with valid_in = 0 is ignored, and no packet is emitted.
- The counter is 8 bits and is never allowed to wrap; TIMEOUT ≤ 255 guarantees this.

Test Plan:
1. ALU op: valid_in = 1, memop = 0, aluResult = 0x1234, regWrite = 1, writeReg = 5 -> next cycle wb_valid = 1, wb_data = 0x1234, wb_reg = 5, wb_regWrite = 1; mem_stall_out stays 0.
2. Load hit: memRead = 1, memToReg = 1, done_reading = 1 in the same cycle, readData = 0xBEEF -> next cycle wb_data = 0xBEEF, wb_valid = 1; no stall.
3. Load miss: memRead = 1, done_reading asserted 4 cycles later with readData = 0xCAFE ->
   - mem_stall_out = 1 for exactly 4 cycles;
   - a single wb_valid pulse with wb_data = 0xCAFE, using the latched writeReg even though inputs toggle during the stall.
4. Store miss: memWrite = 1, regWrite = 0, done after 3 cycles -> 3 stall cycles, then wb_valid = 1, wb_regWrite = 0, wb_err = 0.
5. Timeout: TIMEOUT = 8, load, done_reading never asserts ->
   - mem_stall_out high for 8 cycles, then low;
   - next edge: wb_valid = 1, wb_err = 1, wb_regWrite = 0, wb_data = 0x0000.
6. Reset/error:
   - rst pulse mid-WAIT -> all outputs 0; a later done_reading produces no packet.
   - Separately, a load hit with err = 1 -> wb_err = 1, wb_regWrite = 0.
   - HALT = 1 ALU op -> wb_halt = 1 for one cycle.
